// File: rtl/axi_master_write_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_write_pkg
// Description : Shared state codes, AXI field constants and burst-length
//               helper for the DDR3 AXI write master.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_master_write_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WA_WAIT = 3'd1,
    ST_WA_HS   = 3'd2,
    ST_WD_PROC = 3'd3,
    ST_WB_WAIT = 3'd4,
    ST_WR_DONE = 3'd5
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

  // Beat count clamped to the burst limit, returned in AWLEN (beats-1) form.
  function automatic logic [7:0] burst_awlen(input logic [9:0] len,
                                             input int unsigned max_len);
    logic [9:0] clamped;
    clamped = (len > 10'(max_len)) ? 10'(max_len) : len;
    return 8'(clamped - 10'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_master_write.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_write
// Description : Single INCR-burst AXI write master feeding 64-bit beats from
//               an FWFT FIFO into the DDR3 controller's AXI slave port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_master_write
  import axi_master_write_pkg::*;
#(
  parameter logic [3:0]  C_AXI_ID  = 4'b1111,
  parameter int unsigned C_MAX_LEN = 256
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic [3:0]  M_AXI_AWID,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [1:0]  M_AXI_AWLOCK,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [3:0]  M_AXI_AWQOS,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [3:0]  M_AXI_BID,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic        WR_START,
  input  logic [31:0] WR_ADRS,
  input  logic [9:0]  WR_LEN,
  output logic        WR_READY,
  output logic        WR_FIFO_RE,
  input  logic [63:0] WR_FIFO_DATA,
  output logic        WR_DONE,
  output logic        WR_ERR
);

  wr_state_e   r_state;
  wr_state_e   w_next;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        w_start_ok;
  logic        w_last;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_bready;
  logic        w_done;
  logic        w_idle;
  logic        w_unused;

  assign w_start_ok = WR_START && (WR_LEN != 10'd0);
  assign w_last     = (r_cnt == r_awlen);
  assign w_unused   = ^M_AXI_BID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= ST_IDLE;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_start_ok) begin
        r_awaddr <= WR_ADRS;
        r_awlen  <= burst_awlen(WR_LEN, C_MAX_LEN);
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == ST_WD_PROC && M_AXI_WREADY)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == ST_WB_WAIT && M_AXI_BVALID)
        r_err <= (M_AXI_BRESP != AXI_RESP_OKAY);
    end
  end

  // All handshake outputs decode straight from the state register.
  always_comb begin
    w_next    = r_state;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_done    = 1'b0;
    w_idle    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (w_start_ok) w_next = ST_WA_WAIT;
      end
      ST_WA_WAIT: w_next = ST_WA_HS;
      ST_WA_HS: begin
        w_awvalid = 1'b1;
        if (M_AXI_AWREADY) w_next = ST_WD_PROC;
      end
      ST_WD_PROC: begin
        w_wvalid = 1'b1;
        if (M_AXI_WREADY && w_last) w_next = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) w_next = ST_WR_DONE;
      end
      ST_WR_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign M_AXI_AWID    = C_AXI_ID;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = AXI_SIZE_8B;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWLOCK  = 2'b00;
  assign M_AXI_AWCACHE = AXI_CACHE_DEF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_WDATA   = WR_FIFO_DATA;
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WLAST   = w_wvalid && w_last;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign WR_READY      = w_idle;
  assign WR_FIFO_RE    = w_wvalid && M_AXI_WREADY;
  assign WR_DONE       = w_done;
  assign WR_ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_master_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_master_write
// Description : Self-checking bench: vector table, random bursts against a
//               burst-level model, plus reset / ignored-start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_write;

  localparam int FIFO_DEPTH = 8192;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [1:0]  M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [3:0]  M_AXI_BID = 4'h5;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic        WR_START = 1'b0;
  logic [31:0] WR_ADRS = '0;
  logic [9:0]  WR_LEN = '0;
  logic        WR_READY;
  logic        WR_FIFO_RE;
  logic [63:0] WR_FIFO_DATA;
  logic        WR_DONE;
  logic        WR_ERR;

  axi_master_write dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN), .WR_READY(WR_READY),
    .WR_FIFO_RE(WR_FIFO_RE), .WR_FIFO_DATA(WR_FIFO_DATA), .WR_DONE(WR_DONE), .WR_ERR(WR_ERR)
  );

  always #5 ACLK = ~ACLK;

  // FWFT FIFO model: head word is mem[rd], pop advances rd.
  logic [63:0] mem [FIFO_DEPTH];
  int rd = 0;
  assign WR_FIFO_DATA = mem[rd % FIFO_DEPTH];
  always @(posedge ACLK) if (WR_FIFO_RE) rd <= rd + 1;

  // Burst configuration shared by the task and the slave model.
  int   base = 0;
  int   exp_beats = 0;
  int   aw_delay = 0;
  bit   wrand = 0;
  bit   b_early = 0;
  bit   burst_active = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] exp_addr = '0;

  // Monitor state, written only by the monitor.
  int   aw_total = 0, b_total = 0, done_total = 0, viol_total = 0;
  int   beats = 0, b_beats_last = 0;
  bit   aw_seen = 0, b_seen = 0, stalled = 0, prev_done = 0;
  logic [63:0] st_data = '0;
  logic        st_last = 1'b0;
  logic [31:0] aw_addr_last = '0;
  logic [7:0]  aw_len_last = '0;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (M_AXI_AWVALID) begin
        if (M_AXI_AWID != 4'hF || M_AXI_AWSIZE != 3'b011 || M_AXI_AWBURST != 2'b01 ||
            M_AXI_AWLOCK != 2'b00 || M_AXI_AWCACHE != 4'b0011 || M_AXI_AWPROT != 3'b000 ||
            M_AXI_AWQOS != 4'h0 || M_AXI_AWADDR != exp_addr) viol_total++;
      end
      if (M_AXI_WVALID && !aw_seen) viol_total++;
      if (M_AXI_WSTRB != 8'hFF) viol_total++;
      if (WR_FIFO_RE !== (M_AXI_WVALID & M_AXI_WREADY)) viol_total++;
      if (M_AXI_WVALID) begin
        if (stalled && (M_AXI_WDATA != st_data || M_AXI_WLAST != st_last)) viol_total++;
        if (M_AXI_WDATA != mem[(base + beats) % FIFO_DEPTH]) viol_total++;
        if (M_AXI_WLAST != (beats == exp_beats - 1)) viol_total++;
        if (M_AXI_WREADY) begin
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          st_data = M_AXI_WDATA;
          st_last = M_AXI_WLAST;
        end
      end else if (M_AXI_WLAST) viol_total++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_total++;
        aw_seen = 1;
        aw_addr_last = M_AXI_AWADDR;
        aw_len_last = M_AXI_AWLEN;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_total++;
        b_seen = 1;
        b_beats_last = beats;
      end
      if (WR_DONE) begin
        done_total++;
        if (WR_READY) viol_total++;
      end
      if (prev_done && !WR_READY) viol_total++;
      prev_done = WR_DONE;
      if (WR_READY) begin
        beats = 0;
        stalled = 0;
        aw_seen = 0;
        b_seen = 0;
      end
    end
  end

  // AXI slave model: delayed AWREADY, optional random WREADY, B response.
  initial begin
    int aw_wait;
    aw_wait = 0;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        aw_wait = 0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b0;
      end else begin
        if (M_AXI_AWVALID) begin
          aw_wait++;
          M_AXI_AWREADY = (aw_wait > aw_delay);
        end else begin
          aw_wait = 0;
          M_AXI_AWREADY = 1'b0;
        end
        M_AXI_WREADY = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
        M_AXI_BVALID = burst_active && !b_seen && (b_early || (beats == exp_beats));
        M_AXI_BRESP = bresp_cfg;
      end
    end
  end

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!WR_READY && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
    end
    if (!WR_READY) chk("wait_ready_timeout", 64'(WR_READY), 64'd1);
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [9:0] len,
                           input logic [1:0] bresp, input int awd, input bit wr,
                           input bit be, input bit hold,
                           input logic [7:0] x_awlen, input int x_beats, input bit x_err);
    int aw0, b0, d0, v0, cyc;
    bit got_done;
    wait_ready();
    @(posedge ACLK);
    #1;
    aw0 = aw_total; b0 = b_total; d0 = done_total; v0 = viol_total;
    base = rd; exp_beats = x_beats; exp_addr = addr;
    aw_delay = awd; wrand = wr; b_early = be; bresp_cfg = bresp;
    burst_active = 1;
    WR_START = 1'b1; WR_ADRS = addr; WR_LEN = len;
    @(posedge ACLK);
    #1;
    if (!hold) WR_START = 1'b0;
    @(negedge ACLK);
    chk("err_clear_at_start", 64'(WR_ERR), 64'd0);
    chk("awvalid_not_early", 64'(M_AXI_AWVALID), 64'd0);
    @(negedge ACLK);
    chk("awvalid_two_cycles", 64'(M_AXI_AWVALID), 64'd1);
    got_done = 0;
    cyc = 0;
    while (!got_done && cyc < 4000) begin
      if (WR_DONE) begin
        got_done = 1;
        WR_START = 1'b0;
      end else begin
        @(negedge ACLK);
        cyc++;
      end
    end
    WR_START = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    repeat (4) @(negedge ACLK);
    burst_active = 0;
    chk("aw_count", 64'(aw_total - aw0), 64'd1);
    chk("awaddr", 64'(aw_addr_last), 64'(addr));
    chk("awlen", 64'(aw_len_last), 64'(x_awlen));
    chk("beats", 64'(b_beats_last), 64'(x_beats));
    chk("fifo_pops", 64'(rd - base), 64'(x_beats));
    chk("b_count", 64'(b_total - b0), 64'd1);
    chk("done_count", 64'(done_total - d0), 64'd1);
    chk("protocol_viol", 64'(viol_total - v0), 64'd0);
    chk("wr_err", 64'(WR_ERR), 64'(x_err));
    chk("ready_after", 64'(WR_READY), 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [9:0]  len;
    logic [1:0]  bresp;
    int          awd;
    bit          wr;
    bit          be;
    logic [7:0]  x_awlen;
    int          x_beats;
    bit          x_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int a0, d0;
    logic [31:0] raddr;
    logic [9:0]  rlen;
    logic [1:0]  rresp;
    int model_beats;

    for (int i = 0; i < FIFO_DEPTH; i++) mem[i] = {$urandom, $urandom};

    vecs[0] = '{32'h0000_0100, 10'd8,    2'b00, 0, 1'b0, 1'b0, 8'd7,   8,   1'b0};
    vecs[1] = '{32'h0000_2000, 10'd1,    2'b00, 0, 1'b0, 1'b0, 8'd0,   1,   1'b0};
    vecs[2] = '{32'h0001_0000, 10'd256,  2'b00, 5, 1'b1, 1'b1, 8'd255, 256, 1'b0};
    vecs[3] = '{32'h0000_0400, 10'd4,    2'b10, 0, 1'b0, 1'b0, 8'd3,   4,   1'b1};
    vecs[4] = '{32'h0000_0800, 10'd4,    2'b00, 1, 1'b1, 1'b0, 8'd3,   4,   1'b0};
    vecs[5] = '{32'h0000_3000, 10'd300,  2'b00, 2, 1'b1, 1'b0, 8'd255, 256, 1'b0};
    vecs[6] = '{32'h0000_5000, 10'd1023, 2'b11, 0, 1'b0, 1'b1, 8'd255, 256, 1'b1};
    vecs[7] = '{32'h0000_6008, 10'd2,    2'b01, 3, 1'b1, 1'b0, 8'd1,   2,   1'b1};

    // Reset state, checked while ARESETN is still low.
    #12;
    chk("rst_wr_ready", 64'(WR_READY), 64'd1);
    chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("rst_wlast", 64'(M_AXI_WLAST), 64'd0);
    chk("rst_bready", 64'(M_AXI_BREADY), 64'd0);
    chk("rst_done", 64'(WR_DONE), 64'd0);
    chk("rst_fifo_re", 64'(WR_FIFO_RE), 64'd0);
    chk("rst_awaddr", 64'(M_AXI_AWADDR), 64'd0);
    chk("rst_awlen", 64'(M_AXI_AWLEN), 64'd0);
    chk("rst_err", 64'(WR_ERR), 64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    for (int i = 0; i < 8; i++)
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].bresp, vecs[i].awd, vecs[i].wr,
                vecs[i].be, 1'b0, vecs[i].x_awlen, vecs[i].x_beats, vecs[i].x_err);

    // WR_START held across a whole burst: exactly one burst.
    run_burst(32'h0000_7000, 10'd5, 2'b00, 0, 1'b1, 1'b0, 1'b1, 8'd4, 5, 1'b0);

    // WR_LEN == 0 in IDLE is ignored.
    a0 = aw_total; d0 = done_total;
    @(posedge ACLK); #1;
    WR_START = 1'b1; WR_LEN = 10'd0; WR_ADRS = 32'h0000_9000;
    @(posedge ACLK); #1;
    WR_START = 1'b0;
    repeat (10) @(negedge ACLK);
    chk("len0_no_aw", 64'(aw_total - a0), 64'd0);
    chk("len0_no_done", 64'(done_total - d0), 64'd0);
    chk("len0_ready", 64'(WR_READY), 64'd1);

    // Reset at beat 3 of a 16-beat burst.
    wait_ready();
    @(posedge ACLK); #1;
    base = rd; exp_beats = 16; exp_addr = 32'h0000_A000;
    aw_delay = 0; wrand = 1'b0; b_early = 1'b0; bresp_cfg = 2'b00; burst_active = 1;
    WR_START = 1'b1; WR_ADRS = 32'h0000_A000; WR_LEN = 10'd16;
    @(posedge ACLK); #1;
    WR_START = 1'b0;
    for (int c = 0; c < 50 && beats < 3; c++) @(negedge ACLK);
    chk("reached_beat3", 64'(beats), 64'd3);
    #2;
    ARESETN = 1'b0;
    burst_active = 0;
    #1;
    chk("arst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("arst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("arst_wlast", 64'(M_AXI_WLAST), 64'd0);
    chk("arst_bready", 64'(M_AXI_BREADY), 64'd0);
    chk("arst_fifo_re", 64'(WR_FIFO_RE), 64'd0);
    chk("arst_ready", 64'(WR_READY), 64'd1);
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    run_burst(32'h0000_B000, 10'd16, 2'b00, 1, 1'b1, 1'b0, 1'b0, 8'd15, 16, 1'b0);

    // Random bursts against the burst-level model.
    for (int i = 0; i < 8; i++) begin
      raddr = $urandom;
      raddr = raddr & 32'hFFFF_F000;
      rlen = 10'($urandom_range(1, 320));
      rresp = 2'($urandom_range(0, 3));
      model_beats = (int'(rlen) > 256) ? 256 : int'(rlen);
      run_burst(raddr, rlen, rresp, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 8'(model_beats - 1), model_beats,
                rresp != 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
